// File: rtl/add_tree_accum.sv
// add_tree_accum: sums NUM_IN signed operands per beat through a registered adder
// tree, accumulates first/last framed beats and emits one result per frame.
// Build option: define ADD_SAT_EN to clamp out_data (and flag out_sat) instead of wrapping.
`timescale 1ns/1ps
`ifndef ADD_OUT_WIDTH
`define ADD_OUT_WIDTH 16
`endif

module add_tree_accum #(
  parameter int DATA_WIDTH = `ADD_OUT_WIDTH,
  parameter int NUM_IN     = 8,
  parameter int ACC_GUARD  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic                         in_first,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_sat
);

  localparam int LEVELS    = $clog2(NUM_IN);
  localparam int SUM_W     = DATA_WIDTH + LEVELS;
  localparam int ACC_WIDTH = DATA_WIDTH + LEVELS + ACC_GUARD;

  logic stall;

  logic [LEVELS-1:0] vld_q, vld_d;
  logic [LEVELS-1:0] first_q, first_d;
  logic [LEVELS-1:0] last_q, last_d;

  logic signed [SUM_W-1:0]     tree_sum;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        acc_vld_q, acc_vld_d;
  logic                        acc_last_q, acc_last_d;

  logic [DATA_WIDTH-1:0] narrow;
  logic                  narrow_sat;
  logic                  out_load;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_sat_q, out_sat_d;

  logic [DATA_WIDTH-1:0] op [NUM_IN];

  // A held result freezes the whole pipe, so upstream must see not-ready at once.
  always_comb begin
    stall = out_valid_q && !out_ready;
  end

  assign in_ready = !stall;

  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      op[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Beat valid and framing flags ride alongside the tree data, one bit per level.
  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;
    if (!stall) begin
      vld_d   = (vld_q << 1)   | LEVELS'(in_valid);
      first_d = (first_q << 1) | LEVELS'(in_first);
      last_d  = (last_q << 1)  | LEVELS'(in_last);
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int SRC_W = DATA_WIDTH + l;
    localparam int W     = SRC_W + 1;
    localparam int N     = NUM_IN >> (l + 1);

    logic [SRC_W-1:0] src   [2*N];
    logic [W-1:0]     sum_d [N];
    logic [W-1:0]     sum_q [N];

    if (l == 0) begin : g_src
      always_comb begin
        for (int i = 0; i < 2*N; i++) begin
          src[i] = op[i];
        end
      end
    end else begin : g_src
      always_comb begin
        for (int i = 0; i < 2*N; i++) begin
          src[i] = g_lvl[l-1].sum_q[i];
        end
      end
    end

    // One bit of sign extension per level keeps every partial sum exact.
    always_comb begin
      for (int i = 0; i < N; i++) begin
        sum_d[i] = {src[2*i][SRC_W-1], src[2*i]} + {src[2*i+1][SRC_W-1], src[2*i+1]};
      end
    end

    // NOTE: tree data registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
      if (!stall) begin
        for (int i = 0; i < N; i++) begin
          sum_q[i] <= sum_d[i];
        end
      end
    end
  end

  always_comb begin
    tree_sum = g_lvl[LEVELS-1].sum_q[0];
  end

  // Bubbles leave the accumulator untouched; a non-first beat adds onto whatever is held.
  always_comb begin
    acc_d      = acc_q;
    acc_vld_d  = acc_vld_q;
    acc_last_d = acc_last_q;
    if (!stall) begin
      acc_vld_d  = vld_q[LEVELS-1];
      acc_last_d = last_q[LEVELS-1];
      if (vld_q[LEVELS-1]) begin
        acc_d = first_q[LEVELS-1] ? ACC_WIDTH'(tree_sum) : acc_q + ACC_WIDTH'(tree_sum);
      end
    end
  end

`ifdef ADD_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    narrow     = acc_q[DATA_WIDTH-1:0];
    narrow_sat = 1'b0;
    if (acc_q > SAT_MAX) begin
      narrow     = SAT_MAX[DATA_WIDTH-1:0];
      narrow_sat = 1'b1;
    end else if (acc_q < SAT_MIN) begin
      narrow     = SAT_MIN[DATA_WIDTH-1:0];
      narrow_sat = 1'b1;
    end
  end
`else
  always_comb begin
    narrow     = acc_q[DATA_WIDTH-1:0];
    narrow_sat = 1'b0;
  end
`endif

  // A taken result may be replaced on the same edge, giving back-to-back output.
  always_comb begin
    out_load    = !stall && acc_vld_q && acc_last_q;
    out_valid_d = stall ? out_valid_q : (acc_vld_q && acc_last_q);
    out_data_d  = out_load ? narrow : out_data_q;
    out_sat_d   = out_load ? narrow_sat : out_sat_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      acc_vld_q   <= 1'b0;
      acc_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      acc_vld_q   <= acc_vld_d;
      acc_last_q  <= acc_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_add_tree_accum.sv
// Self-checking bench for add_tree_accum (DATA_WIDTH=16, NUM_IN=8): directed frames
// plus random framed traffic against a plain-arithmetic frame-sum scoreboard.
`timescale 1ns/1ps

module tb_add_tree_accum;

  localparam int DW = 16;
  localparam int NI = 8;
  localparam int AW = DW + 3 + 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          sat;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_first, in_last;
  logic [NI*DW-1:0] in_data;
  logic             out_valid, out_sat;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;

  int checks = 0;
  int errors = 0;

  logic ready_val;
  logic rand_ready;

  res_t          exp_q[$];
  longint        acc_m;
  int            n_out = 0;
  logic [DW-1:0] last_out;
  logic          last_sat;
  logic          held;
  logic [DW-1:0] held_data;
  logic          held_sat;

  always #5 clk = ~clk;

  add_tree_accum #(.DATA_WIDTH(DW), .NUM_IN(NI), .ACC_GUARD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint beat_sum(input logic [NI*DW-1:0] d);
    longint s = 0;
    for (int k = 0; k < NI; k++) s += longint'($signed(d[k*DW +: DW]));
    return s;
  endfunction

  function automatic res_t narrow_model(input longint a);
    res_t r;
`ifdef ADD_SAT_EN
    if (a > 32767) begin
      r.data = 16'h7fff; r.sat = 1'b1;
    end else if (a < -32768) begin
      r.data = 16'h8000; r.sat = 1'b1;
    end else begin
      r.data = a[DW-1:0]; r.sat = 1'b0;
    end
`else
    r.data = a[DW-1:0];
    r.sat  = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [NI*DW-1:0] pack_const(input logic [DW-1:0] v);
    return {NI{v}};
  endfunction

  function automatic logic [NI*DW-1:0] pack_idx();
    logic [NI*DW-1:0] d;
    for (int k = 0; k < NI; k++) d[k*DW +: DW] = DW'(k);
    return d;
  endfunction

  // Ready driver: a fixed level or random back-pressure, changed just after each edge.
  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
  end

  // Scoreboard: beats and results are observed mid-cycle, ahead of the edge that takes them.
  always @(negedge clk) begin : mon
    longint s;
    res_t   e;
    if (rst) begin
      exp_q.delete();
      acc_m = 0;
      held  = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s = beat_sum(in_data);
        acc_m = in_first ? s : acc_m + s;
        acc_m = (acc_m <<< (64 - AW)) >>> (64 - AW);
        if (in_last) exp_q.push_back(narrow_model(acc_m));
      end
      if (held) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_data", longint'(out_data), longint'(held_data));
        check("hold_sat", longint'(out_sat), longint'(held_sat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_queue_depth", longint'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", longint'(out_data), longint'(e.data));
          check("out_sat", longint'(out_sat), longint'(e.sat));
        end
        n_out++;
        last_out = out_data;
        last_sat = out_sat;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_sat  = out_sat;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [NI*DW-1:0] d, input logic f, input logic l);
    int   guard = 0;
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) check("send_timeout_cycles", guard, 0);
    in_valid = 1'b0;
    in_first = $urandom_range(0, 1);
    in_last  = $urandom_range(0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int lat;
    int len;
    int g;
    logic [NI*DW-1:0] d;
    logic f;

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = '0;
    ready_val = 1'b1; rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 1);

    // 1: single beat of ones, latency and value
    in_valid = 1'b1; in_data = pack_const(16'd1); in_first = 1'b1; in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("t1_latency", lat, 4);
    check("t1_data", longint'(out_data), 8);
    idle(3);

    // 2: three-beat frame
    n0 = n_out;
    send_beat(pack_const(16'd100), 1'b1, 1'b0);
    send_beat(pack_const(DW'(-50)), 1'b0, 1'b0);
    send_beat(pack_idx(), 1'b0, 1'b1);
    idle(8);
    check("t2_count", n_out - n0, 1);
    check("t2_data", longint'($signed(last_out)), 428);

    // 3: eight single-beat frames with a mid-stream stall
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(pack_const(DW'(i + 1)), 1'b1, 1'b1);
      end
      begin
        idle(3);
        ready_val = 1'b0;
        idle(3);
        check("t3_in_ready_low", longint'(in_ready), 0);
        idle(2);
        ready_val = 1'b1;
      end
    join
    idle(8);
    check("t3_count", n_out - n0, 8);
    check("t3_last", longint'(last_out), 64);

    // 4: four beats of the maximum positive operand
    for (int b = 0; b < 4; b++) send_beat(pack_const(16'd32767), b == 0, b == 3);
    idle(8);
`ifdef ADD_SAT_EN
    check("t4_data", longint'(last_out), 32767);
    check("t4_sat", longint'(last_sat), 1);
`else
    check("t4_data", longint'(last_out), 'hffe0);
    check("t4_sat", longint'(last_sat), 0);
`endif

    // 5: reset with a result presented and three beats in flight
    send_beat(pack_const(16'd5), 1'b1, 1'b1);
    send_beat(pack_const(16'd7), 1'b1, 1'b0);
    send_beat(pack_const(16'd7), 1'b0, 1'b0);
    send_beat(pack_const(16'd7), 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("t5_pre_valid", longint'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", longint'(out_valid), 0);
    check("t5_rst_data", longint'(out_data), 0);
    check("t5_rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = n_out;
    idle(10);
    check("t5_no_out", n_out - n0, 0);
    send_beat(pack_const(16'd3), 1'b1, 1'b1);
    idle(6);
    check("t5_new_count", n_out - n0, 1);
    check("t5_new_data", longint'(last_out), 24);

    // 6: random frames, gaps and back-pressure
    rand_ready = 1'b1;
    for (int fr = 0; fr < 60; fr++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < NI; k++) d[k*DW +: DW] = DW'($urandom);
        f = (b == 0) && ($urandom_range(0, 9) != 0);
        send_beat(d, f, b == len - 1);
        idle($urandom_range(0, 2));
      end
    end
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      idle(1);
      g++;
    end
    check("drain_empty", longint'(exp_q.size()), 0);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
